apuf_switch_chain: RTL and testbench
====================================

Name: apuf_switch_chain

Overview:
- Parametrised successor of the single two-rail challenge switch stage.
- Instantiates N_STAGES switch stages in a chain, each routed by one challenge bit, with pipeline registers on the token rails.
- An FSM launches a one-cycle token per evaluation and captures the rail it exits on.
- Each evaluation yields one response bit. RESP_BITS evaluations run per request, each on a new challenge derived from the last, and the response is returned over a valid/ready handshake.

Parameters:
- N_STAGES, 64, number of switch stages; challenge width.
- REG_EVERY, 1, stages between rail pipeline registers. N_STAGES must be divisible by REG_EVERY. L = N_STAGES/REG_EVERY.
- RESP_BITS, 8, evaluations (response bits) per accepted challenge.

Ports:
- clk, input, 1: single clock, rising edge.
- rst_n, input, 1: synchronous, active-low reset.
- chl_valid, input, 1: challenge offered.
- chl_ready, output, 1: block can accept a challenge.
- chl_data, input, N_STAGES: challenge; bit i drives sel of stage i.
- resp_valid, output, 1: response available.
- resp_ready, input, 1: consumer accepts response.
- resp_data, output, RESP_BITS: response; bit k is evaluation k.
- resp_err, output, 1: at least one evaluation's capture was not one-hot. Valid with resp_valid.
- busy, output, 1: FSM not in IDLE.

Behaviour:
- Reset (rst_n low at a clk edge):
  - FSM goes to IDLE.
  - All rail registers, challenge register, response shift register and eval counter clear to 0.
  - Outputs: chl_ready=1, resp_valid=0, resp_data=0, resp_err=0, busy=0.
  - Reset mid-operation aborts the evaluation immediately; no response is produced.
- Switch stage, per stage i with inputs (a0,a1):
  - sel=0: straight, y0=a0, y1=a1.
  - sel=1: crossed, y0=a1, y1=a0.
  - Sel comes from the internal challenge register, never directly from chl_data.
- Rails:
  - Rail 0 of stage 0 is driven 1 only in the LAUNCH cycle; rail 1 of stage 0 is tied 0.
  - A two-rail register follows every REG_EVERY-th stage, L registers in total.
  - A token launched in cycle t appears at the last register output in cycle t+L.
- FSM states:
  - IDLE: chl_ready=1. On chl_valid&&chl_ready: latch chl_data, clear eval counter and err accumulator, go to LAUNCH.
  - LAUNCH (1 cycle): inject token, clear wait counter, go to PROP.
  - PROP: count cycles. In the cycle the token reaches the last register output (launch cycle + L), sample the rails (capture). Response bit = rail1. If the rails are not exactly one-hot (00 or 11), set the err accumulator.
  - After a capture: store the bit into resp_data[eval], increment eval, and update the challenge to next = {c[N_STAGES-2:0], c[N_STAGES-1]^c[0]}.
  - If eval < RESP_BITS after the increment, the next cycle is LAUNCH; otherwise go to DONE.
  - DONE: resp_valid=1. resp_data and resp_err stay stable until resp_valid&&resp_ready, then return to IDLE (chl_ready=1 the following cycle).
- Timing:
  - Evaluation period is L+1 cycles (launch t, capture t+L, next launch t+L+1).
  - With challenge accepted at cycle T, resp_valid first asserts at T + RESP_BITS*(L+1) + 1.
- Functional identity (fault-free): response bit = XOR of all bits of the challenge used for that evaluation.
- chl_valid outside IDLE is ignored; chl_data changes during evaluation have no effect.
- resp_ready while resp_valid=0 is ignored.
- Backpressure: DONE may hold indefinitely; no new challenge is accepted meanwhile.
- Only one token is in flight at a time; rails are all-zero outside the launch-to-capture window.

Test Plan:
All scenarios use N_STAGES=8, REG_EVERY=2, RESP_BITS=4, so L=4.
1. Reset: hold rst_n=0 for 3 cycles with chl_valid=1 -> chl_ready=1, resp_valid=0, busy=0, resp_data=0, no accept.
2. chl_data=8'h00, resp_ready=1, accepted at cycle T -> resp_valid at T+21, resp_data=4'b0000, resp_err=0.
3. chl_data=8'h01 -> challenges 01,03,07,0F -> resp_data=4'b0101, resp_err=0.
4. chl_data=8'h80 -> challenges 80,01,03,07 -> parities 1,1,0,1 -> resp_data=4'b1011.
5. Backpressure: resp_ready=0 for 10 cycles after resp_valid -> resp_data/resp_err stable, chl_ready=0; pulse resp_ready -> IDLE next cycle; a second challenge 8'h01 again gives 4'b0101.
6. Assert rst_n=0 for one cycle during eval 2 -> IDLE, no resp_valid. Then force both last-register rails to 1 at capture of eval 0 (bench force) -> resp_err=1 with resp_valid.

Source files
------------

// File: rtl/apuf_switch_chain.sv
// Arbiter-PUF style two-rail switch chain with a pipelined token path.
// A single token is launched on rail 0 and steered through N_STAGES
// challenge-controlled switches. The exit rail becomes one response bit.
// RESP_BITS evaluations run per accepted challenge. The challenge is
// advanced by an LFSR-style step after every capture. The packed response
// is returned over a valid/ready handshake.
module apuf_switch_chain #(
    parameter int N_STAGES  = 64,
    parameter int REG_EVERY = 1,
    parameter int RESP_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 chl_valid,
    output logic                 chl_ready,
    input  logic [N_STAGES-1:0]  chl_data,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [RESP_BITS-1:0] resp_data,
    output logic                 resp_err,
    output logic                 busy
);

    // Number of two-rail pipeline registers along the chain.
    localparam int L  = N_STAGES / REG_EVERY;
    localparam int WW = (L > 1) ? $clog2(L) : 1;
    localparam int EW = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;

    localparam logic [WW-1:0] WAIT_LAST = WW'(L - 1);
    localparam logic [EW-1:0] EVAL_LAST = EW'(RESP_BITS - 1);

    if (N_STAGES % REG_EVERY != 0) begin : g_bad_param
        $error("apuf_switch_chain: N_STAGES must be a multiple of REG_EVERY");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_PROP,
        S_DONE
    } state_t;

    state_t                state;
    logic [N_STAGES-1:0]   chl_q;
    logic [EW-1:0]         eval_cnt;
    logic [WW-1:0]         wait_cnt;
    logic [RESP_BITS-1:0]  resp_q;
    logic                  err_q;

    logic [L-1:0]          rail0_q;
    logic [L-1:0]          rail1_q;
    logic [L-1:0]          seg_out0;
    logic [L-1:0]          seg_out1;

    // head*[s] feeds segment s. Index 0 is the launch point.
    // head*[L] is the output of the last register, which is where the token exits.
    logic [L:0]            head0;
    logic [L:0]            head1;
    logic [1:0]            exit_rails;
    logic                  launch;

    assign launch     = (state == S_LAUNCH);
    assign head0      = {rail0_q, launch};
    assign head1      = {rail1_q, 1'b0};
    assign exit_rails = {head1[L], head0[L]};

    assign resp_data  = resp_q;
    assign resp_err   = err_q;

    // Combinational switch stages between registers: straight when sel=0, crossed when sel=1.
    always_comb begin : chain_comb
        logic r0;
        logic r1;
        // NOTE: every variable written here gets a default first, so no path can infer a latch.
        seg_out0 = '0;
        seg_out1 = '0;
        r0       = 1'b0;
        r1       = 1'b0;
        for (int i = 0; i < N_STAGES; i++) begin
            if (i % REG_EVERY == 0) begin
                r0 = head0[i / REG_EVERY];
                r1 = head1[i / REG_EVERY];
            end
            if (chl_q[i]) begin
                {r0, r1} = {r1, r0};
            end
            if (i % REG_EVERY == REG_EVERY - 1) begin
                seg_out0[i / REG_EVERY] = r0;
                seg_out1[i / REG_EVERY] = r1;
            end
        end
    end

    // Two-rail pipeline registers after every REG_EVERY-th stage.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so all flops update together at the edge.
        if (!rst_n) begin
            rail0_q <= '0;
            rail1_q <= '0;
        end else begin
            rail0_q <= seg_out0;
            rail1_q <= seg_out1;
        end
    end

    // Evaluation sequencer: accept, launch, wait L cycles, capture, repeat, hand off.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            chl_q      <= '0;
            eval_cnt   <= '0;
            wait_cnt   <= '0;
            resp_q     <= '0;
            err_q      <= 1'b0;
            chl_ready  <= 1'b1;
            resp_valid <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (chl_valid) begin
                        chl_q     <= chl_data;
                        eval_cnt  <= '0;
                        err_q     <= 1'b0;
                        chl_ready <= 1'b0;
                        busy      <= 1'b1;
                        state     <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    wait_cnt <= '0;
                    state    <= S_PROP;
                end
                S_PROP: begin
                    if (wait_cnt == WAIT_LAST) begin
                        // The token is at the last register output in this cycle.
                        resp_q[eval_cnt] <= exit_rails[1];
                        if (exit_rails[0] == exit_rails[1]) begin
                            err_q <= 1'b1;
                        end
                        chl_q    <= {chl_q[N_STAGES-2:0], chl_q[N_STAGES-1] ^ chl_q[0]};
                        eval_cnt <= eval_cnt + 1'b1;
                        if (eval_cnt == EVAL_LAST) begin
                            resp_valid <= 1'b1;
                            state      <= S_DONE;
                        end else begin
                            state <= S_LAUNCH;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        chl_ready  <= 1'b1;
                        busy       <= 1'b0;
                        state      <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apuf_switch_chain.sv
// Self-checking bench for apuf_switch_chain (N_STAGES=8, REG_EVERY=2, RESP_BITS=4).
// Expected responses come from a parity model of the challenge sequence.
module tb_apuf_switch_chain;

    localparam int N  = 8;
    localparam int RE = 2;
    localparam int RB = 4;
    localparam int L  = N / RE;

    logic          clk;
    logic          rst_n;
    logic          chl_valid;
    logic          chl_ready;
    logic [N-1:0]  chl_data;
    logic          resp_valid;
    logic          resp_ready;
    logic [RB-1:0] resp_data;
    logic          resp_err;
    logic          busy;

    int n_checks = 0;
    int n_errors = 0;

    apuf_switch_chain #(
        .N_STAGES (N),
        .REG_EVERY(RE),
        .RESP_BITS(RB)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .chl_valid (chl_valid),
        .chl_ready (chl_ready),
        .chl_data  (chl_data),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_data (resp_data),
        .resp_err  (resp_err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare, count, and report one observation.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: bit k is the parity of the k-th challenge in the sequence.
    function automatic logic [RB-1:0] model_resp(input logic [N-1:0] c);
        logic [N-1:0]  cur;
        logic [RB-1:0] r;
        cur = c;
        r   = '0;
        for (int k = 0; k < RB; k++) begin
            r[k] = ($countones(cur) % 2) == 1;
            cur  = (cur << 1) | N'(cur[N-1] ^ cur[0]);
        end
        return r;
    endfunction

    // One full request: offer, run, observe response, optional backpressure, consume.
    task automatic run_txn(input logic [N-1:0] chl, input int hold, input bit inject,
                           input logic [RB-1:0] exp_data, input bit exp_err, input string tag);
        int n;
        bit seen;
        n = 0;
        @(negedge clk);
        while (!chl_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_ready"}, 32'(chl_ready), 32'd1);
        chl_valid  = 1'b1;
        chl_data   = chl;
        resp_ready = 1'($urandom_range(0, 1));
        @(posedge clk);
        n    = 0;
        seen = 1'b0;
        while (n < 200) begin
            @(negedge clk);
            n++;
            if (inject && n == L + 1) force dut.exit_rails = 2'b11;
            if (inject && n == L + 2) release dut.exit_rails;
            if (n == 1) check({tag, "_busy"}, 32'({busy, chl_ready}), 32'b10);
            if (resp_valid) begin
                seen = 1'b1;
                break;
            end
            // Inputs wiggle during evaluation; none of this may matter.
            chl_valid  = 1'($urandom_range(0, 1));
            chl_data   = N'($urandom);
            resp_ready = 1'($urandom_range(0, 1));
        end
        check({tag, "_seen"}, 32'(seen), 32'd1);
        check({tag, "_lat"}, 32'(n), 32'(RB * (L + 1) + 1));
        check({tag, "_data"}, 32'(resp_data), 32'(exp_data));
        check({tag, "_err"}, 32'(resp_err), 32'(exp_err));
        resp_ready = 1'b0;
        chl_valid  = 1'b1;
        chl_data   = N'($urandom);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, "_hold"}, 32'({resp_valid, chl_ready, resp_err, resp_data}),
                  32'({1'b1, 1'b0, exp_err, exp_data}));
        end
        chl_valid  = 1'b0;
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        check({tag, "_idle"}, 32'({chl_ready, resp_valid, busy}), 32'b100);
    endtask

    initial begin
        int n;
        int vcount;
        logic [N-1:0] c;

        // Reset with a challenge offered: nothing may be accepted.
        rst_n      = 1'b0;
        chl_valid  = 1'b1;
        chl_data   = 8'hFF;
        resp_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out", 32'({chl_ready, resp_valid, busy, resp_err, resp_data}),
              32'({1'b1, 1'b0, 1'b0, 1'b0, 4'b0000}));
        chl_valid = 1'b0;
        rst_n     = 1'b1;
        @(negedge clk);
        check("rst_noacc", 32'({busy, chl_ready}), 32'b01);

        run_txn(8'h00, 0, 1'b0, 4'b0000, 1'b0, "zero");
        run_txn(8'h01, 0, 1'b0, 4'b0101, 1'b0, "one");
        run_txn(8'h80, 0, 1'b0, 4'b1011, 1'b0, "msb");
        run_txn(8'h01, 10, 1'b0, 4'b0101, 1'b0, "bp");
        run_txn(8'h01, 0, 1'b0, 4'b0101, 1'b0, "bp2");

        // Reset during evaluation 2 aborts without a response.
        @(negedge clk);
        chl_valid = 1'b1;
        chl_data  = 8'h5A;
        @(posedge clk);
        chl_valid = 1'b0;
        n = 0;
        while (n < 2 * (L + 1) + 2) begin
            @(negedge clk);
            n++;
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_out", 32'({chl_ready, resp_valid, busy, resp_err, resp_data}),
              32'({1'b1, 1'b0, 1'b0, 1'b0, 4'b0000}));
        vcount = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (resp_valid || busy) vcount++;
        end
        check("abort_quiet", 32'(vcount), 32'd0);

        // Both exit rails high at capture of evaluation 0 flags an error.
        run_txn(8'h00, 2, 1'b1, 4'b0001, 1'b1, "inj");
        run_txn(8'h01, 0, 1'b0, 4'b0101, 1'b0, "inj_clr");

        // Random challenges against the parity model.
        for (int t = 0; t < 10; t++) begin
            c = N'($urandom);
            run_txn(c, int'($urandom_range(0, 3)), 1'b0, model_resp(c), 1'b0, "rnd");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Watchdog against a stuck run.
    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
